// File: rtl/bus_arb_defs_pkg.sv
// Shared definitions for the round-robin arbiter and its client request agents:
// agent FSM encoding and four-phase handshake signal levels.
package bus_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } agent_state_e;

    localparam logic RQ_ASSERTED  = 1'b1;
    localparam logic RQ_RELEASED  = 1'b0;
    localparam logic ACK_ASSERTED = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty/count; no same-cycle pass-through.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic                                pop,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count_nxt_c
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign count_nxt_c = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    assign rd_data     = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == CNT_W'(FIFO_DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

endmodule

// File: rtl/client_rq_agent.sv
// Client-side agent: buffers words from client logic and issues each one to the
// arbiter as a four-phase rq/ack handshake, abandoning words on ack timeout.
module client_rq_agent
    import bus_arb_defs::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic                            wr_ready,
    output logic                            client_rq,
    input  logic                            client_ack,
    output logic [DATA_WIDTH-1:0]           client_data,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] pending_count,
    output logic                            timeout_err,
    input  logic                            err_clr
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    agent_state_e          state;
    agent_state_e          state_nxt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [TMO_W-1:0]      tmo_cnt_nxt;
    logic                  rq_nxt;
    logic                  load_data;
    logic                  pop;
    logic                  err_set;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CNT_W-1:0]      count_nxt;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (wr_valid),
        .pop         (pop),
        .wr_data     (wr_data),
        .rd_data     (head_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (pending_count),
        .count_nxt_c (count_nxt)
    );

    assign wr_ready = !fifo_full;

    // A high ack in IDLE is a protocol violation; hold off the next request until it drops.
    always_comb begin
        state_nxt   = state;
        rq_nxt      = RQ_RELEASED;
        tmo_cnt_nxt = '0;
        load_data   = 1'b0;
        pop         = 1'b0;
        err_set     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && (client_ack != ACK_ASSERTED)) begin
                    state_nxt = ST_REQ;
                    rq_nxt    = RQ_ASSERTED;
                    load_data = 1'b1;
                end
            end
            ST_REQ: begin
                if (client_ack == ACK_ASSERTED) begin
                    state_nxt = ST_REL;
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = ST_REL;
                    err_set   = 1'b1;
                end else begin
                    rq_nxt      = RQ_ASSERTED;
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            ST_REL: begin
                if (client_ack != ACK_ASSERTED) begin
                    pop       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            client_rq   <= RQ_RELEASED;
            client_data <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            client_rq <= rq_nxt;
            busy      <= (state_nxt != ST_IDLE) || (count_nxt != '0);
            if (load_data) begin
                client_data <= head_data;
            end
            // Set takes priority over a simultaneous clear.
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_client_rq_agent.sv
// Scoreboard bench for client_rq_agent: directed pushes queue expected words,
// a monitor checks every request the agent raises against that queue.
module tb_client_rq_agent;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          client_rq;
    logic          client_ack;
    logic [DW-1:0] client_data;
    logic          busy;
    logic [2:0]    pending_count;
    logic          timeout_err;
    logic          err_clr;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [DW-1:0] exp_q[$];

    client_rq_agent #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .client_rq     (client_rq),
        .client_ack    (client_ack),
        .client_data   (client_data),
        .busy          (busy),
        .pending_count (pending_count),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        exp_q.push_back(d);
        tick();
        wr_valid = 1'b0;
    endtask

    // Arbiter model: wait (bounded) for rq, hold off 'delay' cycles, then full handshake.
    task automatic serve(input int delay);
        int n = 0;
        while (!client_rq && n < 40) begin
            tick();
            n++;
        end
        chk("rq_seen", 32'(client_rq), 32'd1);
        repeat (delay) tick();
        client_ack = 1'b1;
        tick();
        chk("rq_drop_on_ack", 32'(client_rq), 32'd0);
        client_ack = 1'b0;
        tick();
    endtask

    // Monitor: each rising rq must carry the next expected word with >=2 low cycles before it.
    logic          mon_prev = 1'b0;
    logic          mon_first = 1'b1;
    int unsigned   mon_low = 0;
    logic [DW-1:0] mon_cur = '0;

    always @(negedge clk) begin
        if (rst) begin
            mon_prev  <= 1'b0;
            mon_first <= 1'b1;
            mon_low   <= 0;
        end else begin
            if (client_rq && !mon_prev) begin
                if (!mon_first) begin
                    chk("rq_low_gap", 32'(mon_low >= 2), 32'd1);
                end
                mon_first <= 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rq", 32'd1, 32'd0);
                end else begin
                    mon_cur = exp_q.pop_front();
                    chk("rq_data", 32'(client_data), 32'(mon_cur));
                end
            end
            if (!client_rq && mon_prev) begin
                chk("data_stable", 32'(client_data), 32'(mon_cur));
            end
            mon_low  <= client_rq ? 0 : mon_low + 1;
            mon_prev <= client_rq;
        end
    end

    initial begin
        int n;
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_data    = '0;
        client_ack = 1'b0;
        err_clr    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_rq", 32'(client_rq), 32'd0);
        chk("rst_data", 32'(client_data), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_count", 32'(pending_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);

        // Single transfer
        push(8'hA5);
        chk("single_count", 32'(pending_count), 32'd1);
        chk("single_rq_latency", 32'(client_rq), 32'd0);
        tick();
        chk("single_rq_up", 32'(client_rq), 32'd1);
        repeat (3) tick();
        client_ack = 1'b1;
        tick();
        chk("single_rq_down", 32'(client_rq), 32'd0);
        chk("single_count_rel", 32'(pending_count), 32'd1);
        client_ack = 1'b0;
        tick();
        chk("single_count_pop", 32'(pending_count), 32'd0);
        chk("single_busy", 32'(busy), 32'd0);
        tick();

        // Back-to-back fill, fifth word refused
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        chk("b2b_full_count", 32'(pending_count), 32'd4);
        chk("b2b_ready_low", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        tick();
        wr_valid = 1'b0;
        chk("b2b_5th_refused", 32'(pending_count), 32'd4);

        // Full boundary: ack the head, then offer a word through the pop edge
        client_ack = 1'b1;
        tick();
        chk("full_rq_down", 32'(client_rq), 32'd0);
        client_ack = 1'b0;
        wr_valid   = 1'b1;
        wr_data    = 8'h05;
        chk("full_ready_before_pop", 32'(wr_ready), 32'd0);
        tick();
        chk("full_count_after_pop", 32'(pending_count), 32'd3);
        chk("full_ready_after_pop", 32'(wr_ready), 32'd1);
        exp_q.push_back(8'h05);
        tick();
        wr_valid = 1'b0;
        chk("full_count_refill", 32'(pending_count), 32'd4);
        repeat (4) serve(1);
        chk("b2b_drained", 32'(pending_count), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd0);
        tick();

        // Timeout: never ack
        push(8'h3C);
        tick();
        n = 0;
        while (client_rq && n < 30) begin
            n++;
            tick();
        end
        chk("tmo_rq_high_cycles", 32'(n), 32'd8);
        chk("tmo_err_set", 32'(timeout_err), 32'd1);
        tick();
        chk("tmo_word_dropped", 32'(pending_count), 32'd0);
        chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_err_cleared", 32'(timeout_err), 32'd0);
        tick();

        // Reset mid-transaction with three pending words
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("mid_rq_high", 32'(client_rq), 32'd1);
        chk("mid_count", 32'(pending_count), 32'd3);
        rst = 1'b1;
        tick();
        chk("mid_rst_rq", 32'(client_rq), 32'd0);
        chk("mid_rst_count", 32'(pending_count), 32'd0);
        chk("mid_rst_ready", 32'(wr_ready), 32'd1);
        exp_q.delete();
        rst = 1'b0;
        n = 0;
        repeat (10) begin
            tick();
            if (client_rq) n++;
        end
        chk("mid_no_rq_after_rst", 32'(n), 32'd0);

        // Protocol violation: ack held high while idle with data pending
        client_ack = 1'b1;
        push(8'h5A);
        repeat (5) tick();
        chk("viol_no_rq", 32'(client_rq), 32'd0);
        chk("viol_busy", 32'(busy), 32'd1);
        client_ack = 1'b0;
        tick();
        chk("viol_rq_after_ack_low", 32'(client_rq), 32'd1);
        serve(1);
        chk("viol_drained", 32'(pending_count), 32'd0);
        tick();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
